// File: rtl/regfile_wport_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wport_arbiter
//
// Purpose:
//   Shares the single write port of a 32-entry register file among NUM_REQ
//   requesters (ALU writeback, load unit, move unit, ...). After reset, or on
//   a clear pulse, the block first zero-fills every register. It then
//   arbitrates round-robin among the requesters. All write-port outputs are
//   registered.
//
// Optional feature (compile-time macro REGFILE_ZERO_REG_EN):
//   Defined   : register 0 is hard-wired zero. The zero-fill covers addresses
//               1..31 only. A granted request that targets address 0 still
//               gets its gnt pulse, but wr_en stays low for that cycle.
//   Undefined : address 0 is an ordinary register. The zero-fill covers
//               addresses 0..31.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   req       in   [NUM_REQ]         per-requester write request, held until granted
//   req_addr  in   [NUM_REQ*ADDR_W]  requester i address at [i*ADDR_W +: ADDR_W]
//   req_data  in   [NUM_REQ*DATA_W]  requester i data at [i*DATA_W +: DATA_W]
//   clear     in   one-cycle pulse that re-runs the zero-fill (ignored while filling)
//   gnt       out  [NUM_REQ]  one-hot grant pulse, registered
//   wr_en     out  register-file write enable, registered
//   wr_addr   out  [ADDR_W]   write address to the 5-to-32 decoder, registered
//   wr_data   out  [DATA_W]   write data, registered
//   busy      out  high while the zero-fill is in progress
// ---------------------------------------------------------------------------
module regfile_wport_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      clear,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
`ifdef REGFILE_ZERO_REG_EN
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FIRST_ADDR = '0;
`endif

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [NUM_REQ-1:0]  r_gnt;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;

    state_t              w_state_nx;
    logic [ADDR_W-1:0]   w_clr_cnt_nx;
    logic [PTR_W-1:0]    w_rr_ptr_nx;
    logic [NUM_REQ-1:0]  w_gnt_nx;
    logic                w_wr_en_nx;
    logic [ADDR_W-1:0]   w_wr_addr_nx;
    logic [DATA_W-1:0]   w_wr_data_nx;

    logic [NUM_REQ-1:0]  w_elig;
    logic                w_found;
    logic [PTR_W-1:0]    w_win;
    logic [PTR_W-1:0]    w_win_inc;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;

    // A requester granted last cycle is masked for one cycle so that it has
    // time to drop (or replace) its request before it can win again.
    assign w_elig = req & ~r_gnt;

    // Round-robin search starting at r_rr_ptr. NUM_REQ need not be a power of
    // two, so the index is wrapped by an explicit compare, not by truncation.
    always_comb begin
        logic [PTR_W:0] v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (v_idx >= (PTR_W+1)'(NUM_REQ)) begin
                v_idx = v_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_found && w_elig[v_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = v_idx[PTR_W-1:0];
            end
        end
    end

    assign w_win_inc  = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    assign w_sel_addr = req_addr[w_win*ADDR_W +: ADDR_W];
    assign w_sel_data = req_data[w_win*DATA_W +: DATA_W];

    // Next-state and next-output logic. The write outputs hold their values
    // whenever nothing is written.
    always_comb begin
        w_state_nx   = r_state;
        w_clr_cnt_nx = r_clr_cnt;
        w_rr_ptr_nx  = r_rr_ptr;
        w_gnt_nx     = '0;
        w_wr_en_nx   = 1'b0;
        w_wr_addr_nx = r_wr_addr;
        w_wr_data_nx = r_wr_data;
        case (r_state)
            CLEAR: begin
                w_wr_en_nx   = 1'b1;
                w_wr_addr_nx = r_clr_cnt;
                w_wr_data_nx = '0;
                w_clr_cnt_nx = r_clr_cnt + 1'b1;
                // Leaving on the edge that presents the last address lets
                // arbitration start in the same cycle that write is visible.
                if (r_clr_cnt == LAST_ADDR) begin
                    w_state_nx = ARB;
                end
            end
            ARB: begin
                if (clear) begin
                    // A clear takes priority over any pending request. That
                    // request stays pending until the fill completes.
                    w_state_nx   = CLEAR;
                    w_clr_cnt_nx = FIRST_ADDR;
                end else if (w_found) begin
                    w_gnt_nx[w_win] = 1'b1;
`ifdef REGFILE_ZERO_REG_EN
                    w_wr_en_nx      = (w_sel_addr != '0);
`else
                    w_wr_en_nx      = 1'b1;
`endif
                    w_wr_addr_nx    = w_sel_addr;
                    w_wr_data_nx    = w_sel_data;
                    w_rr_ptr_nx     = w_win_inc;
                end
            end
            default: begin
                w_state_nx   = CLEAR;
                w_clr_cnt_nx = FIRST_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_cnt <= FIRST_ADDR;
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_clr_cnt <= w_clr_cnt_nx;
            r_rr_ptr  <= w_rr_ptr_nx;
            r_gnt     <= w_gnt_nx;
            r_wr_en   <= w_wr_en_nx;
            r_wr_addr <= w_wr_addr_nx;
            r_wr_data <= w_wr_data_nx;
        end
    end

    assign gnt     = r_gnt;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = (r_state == CLEAR);

endmodule
